kplic: RTL and testbench

KPLIC -- requirements
Module: kplic

---
 rtl/kplic.sv | 95 +++++++++
 tb/tb_kplic.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/kplic.sv
// kplic: small level/edge-gated interrupt controller with claim/complete handshake.
// Define KPLIC_EDGE_TRIG_EN to switch the gateway to rising-edge detection.
module kplic #(
  parameter int NUM_SRC = 8
) (
  input  logic               cpu_clk,
  input  logic               cpu_rstn,
  input  logic [NUM_SRC-1:0] ext_int,
  input  logic               kplic_sel,
  input  logic               kplic_wr,
  input  logic [7:0]         kplic_addr,
  input  logic [31:0]        kplic_wdata,
  output logic [31:0]        kplic_rdata,
  output logic               kplic_int
);
  logic [NUM_SRC-1:0] s1_q, s2_q, set_vec, claim_vec, done_vec;
  logic [NUM_SRC-1:0] pending_q, pending_d, in_service_q, in_service_d, enable_q, enable_d;
  logic [NUM_SRC-1:0][2:0] prio_q, prio_d;
  logic [2:0] threshold_q, threshold_d, best_prio;
  logic [3:0] best_id;
  logic [31:0] rdata_q, rdata_d, prio_rd;
  logic irq_q, irq_d;
  logic [5:0] widx;
  logic wr_en, rd_en, unused_ok;
  assign widx = kplic_addr[7:2];
  assign wr_en = kplic_sel & kplic_wr;
  assign rd_en = kplic_sel & ~kplic_wr;
  assign kplic_rdata = rdata_q;
  assign kplic_int = irq_q;
  assign unused_ok = ^{kplic_addr[1:0], kplic_wdata};
`ifdef KPLIC_EDGE_TRIG_EN
  logic [NUM_SRC-1:0] s3_q;
  assign set_vec = s2_q & ~s3_q & ~pending_q;
  // edge-detect history of the synchronized inputs
  always_ff @(posedge cpu_clk or negedge cpu_rstn)
    if (!cpu_rstn) s3_q <= '0;
    else s3_q <= s2_q;
`else
  assign set_vec = s2_q & ~pending_q & ~in_service_q;
`endif
  // arbitration, claim/complete decode, register writes and read mux
  always_comb begin
    best_id = '0;
    best_prio = '0;
    prio_rd = '0;
    claim_vec = '0;
    done_vec = '0;
    prio_d = prio_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending_q[i] && enable_q[i] && prio_q[i] > best_prio) begin
        best_id = 4'(i + 1);
        best_prio = prio_q[i];
      end
      if (widx == 6'(4 + i)) prio_rd = 32'(prio_q[i]);
      if (wr_en && widx == 6'(4 + i)) prio_d[i] = kplic_wdata[2:0];
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_vec[i] = rd_en && widx == 6'd3 && best_id == 4'(i + 1);
      done_vec[i] = wr_en && widx == 6'd3 && kplic_wdata[7:0] == 8'(i + 1);
    end
    pending_d = (pending_q | set_vec) & ~claim_vec;
    in_service_d = (in_service_q | claim_vec) & ~done_vec;
    enable_d = (wr_en && widx == 6'd1) ? kplic_wdata[NUM_SRC-1:0] : enable_q;
    threshold_d = (wr_en && widx == 6'd2) ? kplic_wdata[2:0] : threshold_q;
    irq_d = (best_id != 4'd0) && (best_prio > threshold_q);
    rdata_d = !rd_en ? rdata_q :
              widx == 6'd0 ? 32'(pending_q) :
              widx == 6'd1 ? 32'(enable_q) :
              widx == 6'd2 ? 32'(threshold_q) :
              widx == 6'd3 ? 32'(best_id) : prio_rd;
  end
  // state registers with asynchronous clear
  always_ff @(posedge cpu_clk or negedge cpu_rstn)
    if (!cpu_rstn) begin
      s1_q <= '0;
      s2_q <= '0;
      pending_q <= '0;
      in_service_q <= '0;
      enable_q <= '0;
      threshold_q <= '0;
      prio_q <= '0;
      rdata_q <= '0;
      irq_q <= 1'b0;
    end else begin
      s1_q <= ext_int;
      s2_q <= s1_q;
      pending_q <= pending_d;
      in_service_q <= in_service_d;
      enable_q <= enable_d;
      threshold_q <= threshold_d;
      prio_q <= prio_d;
      rdata_q <= rdata_d;
      irq_q <= irq_d;
    end
endmodule

// File: tb/tb_kplic.sv
// tb_kplic: directed-vector self-checking bench for kplic.
module tb_kplic;
`ifdef KPLIC_EDGE_TRIG_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  logic cpu_clk = 1'b0, cpu_rstn = 1'b0, kplic_sel = 1'b0, kplic_wr = 1'b0, kplic_int;
  logic [7:0] ext_int = '0, kplic_addr = '0;
  logic [31:0] kplic_wdata = '0, kplic_rdata;
  int n_vec = 0, n_bad = 0;
  always #5 cpu_clk = ~cpu_clk;
  kplic #(.NUM_SRC(8)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .ext_int(ext_int), .kplic_sel(kplic_sel),
    .kplic_wr(kplic_wr), .kplic_addr(kplic_addr), .kplic_wdata(kplic_wdata),
    .kplic_rdata(kplic_rdata), .kplic_int(kplic_int)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge cpu_clk);
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] v);
    kplic_sel = 1'b1; kplic_wr = 1'b1; kplic_addr = a; kplic_wdata = v;
    @(negedge cpu_clk);
    kplic_sel = 1'b0; kplic_wr = 1'b0;
  endtask
  task automatic rchk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    kplic_sel = 1'b1; kplic_wr = 1'b0; kplic_addr = a;
    @(negedge cpu_clk);
    kplic_sel = 1'b0;
    chk(tag, kplic_rdata, exp);
  endtask
  initial begin
    tick(2);
    chk("rst_int", 32'(kplic_int), 0);
    chk("rst_rdata", kplic_rdata, 0);
    cpu_rstn = 1'b1;
    rchk("rst_pend", 8'h00, 0);
    rchk("rst_en", 8'h04, 0);
    rchk("rst_thr", 8'h08, 0);
    rchk("rst_prio0", 8'h10, 0);
    // scenario 1: single source latency and claim
    wr(8'h18, 3);
    wr(8'h04, 32'h04);
    wr(8'h08, 32'hFF);
    rchk("thr_bits", 8'h08, 7);
    wr(8'h08, 1);
    rchk("en_rb", 8'h04, 32'h04);
    rchk("prio2_rb", 8'h18, 3);
    rchk("unmapped", 8'h30, 0);
    ext_int = 8'h04;
    tick(3);
    chk("s1_int_k2", 32'(kplic_int), 0);
    tick(1);
    chk("s1_int_k3", 32'(kplic_int), 1);
    rchk("s1_pend", 8'h00, 32'h04);
    rchk("s1_claim", 8'h0C, 3);
    tick(1);
    chk("s1_int_off", 32'(kplic_int), 0);
    rchk("s1_pend_insvc", 8'h00, 0);
    ext_int = 8'h00;
    tick(3);
    wr(8'h0C, 3);
    tick(1);
    rchk("s1_pend_done", 8'h00, 0);
    // scenario 2: tie at priority 5 between IDs 2 and 5
    wr(8'h14, 5);
    wr(8'h20, 5);
    wr(8'h04, 32'h12);
    ext_int = 8'h12;
    tick(4);
    chk("s2_int", 32'(kplic_int), 1);
    rchk("s2_claim1", 8'h0C, 2);
    rchk("s2_claim2", 8'h0C, 5);
    // scenario 5: empty claim and bogus completes
    rchk("s5_claim0", 8'h0C, 0);
    rchk("s5_pend", 8'h00, 0);
    wr(8'h0C, 0);
    wr(8'h0C, 9);
    tick(1);
    rchk("s5_bad_cmpl", 8'h00, 0);
    chk("s5_int", 32'(kplic_int), 0);
    ext_int = 8'h00;
    tick(3);
    wr(8'h0C, 2);
    wr(8'h0C, 5);
    tick(1);
    rchk("s2_pend_done", 8'h00, 0);
    // scenario 3: threshold gating
    wr(8'h04, 32'h01);
    wr(8'h10, 5);
    wr(8'h08, 5);
    ext_int = 8'h01;
    tick(4);
    chk("s3_int_thr5", 32'(kplic_int), 0);
    rchk("s3_pend", 8'h00, 32'h01);
    wr(8'h08, 4);
    chk("s3_int_same", 32'(kplic_int), 0);
    tick(1);
    chk("s3_int_thr4", 32'(kplic_int), 1);
    wr(8'h04, 0);
    tick(1);
    chk("s3_int_dis", 32'(kplic_int), 0);
    rchk("s3_pend_kept", 8'h00, 32'h01);
    // scenario 4: re-pend after complete with level held high
    wr(8'h04, 32'h01);
    rchk("s4_claim", 8'h0C, 1);
    rchk("s4_pend0", 8'h00, 0);
    wr(8'h0C, 1);
    tick(1);
    rchk("s4_repend", 8'h00, EDGE ? 32'h0 : 32'h1);
    ext_int = 8'h00;
    tick(3);
    rchk("s4_claim2", 8'h0C, EDGE ? 32'd0 : 32'd1);
    wr(8'h0C, 1);
    // scenario 6: reset while source 3 in service
    wr(8'h08, 0);
    wr(8'h04, 32'h04);
    wr(8'h18, 2);
    ext_int = 8'h04;
    tick(4);
    rchk("s6_claim", 8'h0C, 3);
    cpu_rstn = 1'b0;
    #1;
    chk("s6_rst_rdata", kplic_rdata, 0);
    chk("s6_rst_int", 32'(kplic_int), 0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    rchk("s6_en", 8'h04, 0);
    rchk("s6_thr", 8'h08, 0);
    rchk("s6_prio2", 8'h18, 0);
    rchk("s6_pend", 8'h00, 32'h04);
    chk("s6_int_off", 32'(kplic_int), 0);
    wr(8'h04, 32'h04);
    wr(8'h18, 2);
    chk("s6_int_wait", 32'(kplic_int), 0);
    tick(1);
    chk("s6_int_on", 32'(kplic_int), 1);
    rchk("s6_claim2", 8'h0C, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
